// File: rtl/cnn_window_reader.sv
// 3x3 stride-1 window sequencer for the CNN pixel memory: reads nine taps per window
// and presents each packed window on a valid/ready port. Define CNN_WIN_PAD_EN for zero-padded "same" mode.
module cnn_window_reader #(
    parameter int picture_size     = 28,
    parameter int SIZE_1           = 11,
    parameter int SIZE_9           = 99,
    parameter int SIZE_address_pix = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SIZE_address_pix-1:0]   base_addr,
    output logic                          re_p,
    output logic [SIZE_address_pix-1:0]   read_addressp,
    input  logic signed [SIZE_1-1:0]      qp,
    output logic signed [SIZE_9-1:0]      window,
    output logic                          window_valid,
    input  logic                          window_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int CW = $clog2(picture_size) + 1;
`ifdef CNN_WIN_PAD_EN
    localparam logic [CW-1:0] MAX_IDX = CW'(picture_size - 1);
    localparam logic [31:0]   OFF     = 32'd1;
`else
    localparam logic [CW-1:0] MAX_IDX = CW'(picture_size - 3);
    localparam logic [31:0]   OFF     = 32'd0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_OUT} state_t;

    state_t                        r_state, w_state_nxt;
    logic [SIZE_address_pix-1:0]   r_base, w_base_nxt;
    logic [CW-1:0]                 r_row, r_col, w_row_nxt, w_col_nxt;
    logic [3:0]                    r_k, w_k_nxt;
    logic                          w_last, w_done_nxt, w_pad_nxt;
    logic [SIZE_address_pix-1:0]   w_addr_nxt;

    logic                          r_re_p, r_valid, r_busy, r_done;
    logic [SIZE_address_pix-1:0]   r_addr;
    logic signed [SIZE_9-1:0]      r_window;
    logic                          r_cap_vld, r_cap_zero;
    logic [3:0]                    r_cap_slot;

    // Address arithmetic is done at 32 bits and truncated, so it wraps modulo the address space.
    function automatic logic [SIZE_address_pix-1:0] tap_addr(
        input logic [SIZE_address_pix-1:0] base,
        input logic [CW-1:0]               row,
        input logic [CW-1:0]               col,
        input logic [3:0]                  k
    );
        logic [31:0] sum;
        sum = 32'(base) + (32'(row) + 32'(k) / 32'd3 - OFF) * 32'(picture_size)
            + 32'(col) + 32'(k) % 32'd3 - OFF;
        return sum[SIZE_address_pix-1:0];
    endfunction

`ifdef CNN_WIN_PAD_EN
    // A tap is padding when row+i-1 or col+j-1 falls outside 0..picture_size-1.
    function automatic logic tap_pad(
        input logic [CW-1:0] row,
        input logic [CW-1:0] col,
        input logic [3:0]    k
    );
        logic [31:0] ri;
        logic [31:0] cj;
        ri = 32'(row) + 32'(k) / 32'd3;
        cj = 32'(col) + 32'(k) % 32'd3;
        return (ri == 32'd0) || (ri > 32'(picture_size)) || (cj == 32'd0) || (cj > 32'(picture_size));
    endfunction
`endif

    assign w_last = (r_row == MAX_IDX) && (r_col == MAX_IDX);

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_READ;
                    w_base_nxt  = base_addr;
                    w_row_nxt   = {CW{1'b0}};
                    w_col_nxt   = {CW{1'b0}};
                    w_k_nxt     = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (r_k == 4'd8) begin
                    w_state_nxt = S_DRAIN;
                    w_k_nxt     = 4'd0;
                end else begin
                    w_k_nxt     = r_k + 4'd1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (window_ready) begin
                    w_k_nxt = 4'd0;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_row_nxt   = {CW{1'b0}};
                        w_col_nxt   = {CW{1'b0}};
                        w_done_nxt  = 1'b1;
                    end else if (r_col == MAX_IDX) begin
                        w_state_nxt = S_READ;
                        w_col_nxt   = {CW{1'b0}};
                        w_row_nxt   = r_row + CW'(1);
                    end else begin
                        w_state_nxt = S_READ;
                        w_col_nxt   = r_col + CW'(1);
                    end
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address and padding of the tap issued in the next cycle.
    always_comb begin
        w_addr_nxt = tap_addr(w_base_nxt, w_row_nxt, w_col_nxt, w_k_nxt);
`ifdef CNN_WIN_PAD_EN
        w_pad_nxt  = tap_pad(w_row_nxt, w_col_nxt, w_k_nxt);
`else
        w_pad_nxt  = 1'b0;
`endif
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= {SIZE_address_pix{1'b0}};
            r_row   <= {CW{1'b0}};
            r_col   <= {CW{1'b0}};
            r_k     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Registered outputs; read data for a tap arrives one cycle after its issue and is captured at the end of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_re_p     <= 1'b0;
            r_addr     <= {SIZE_address_pix{1'b0}};
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cap_vld  <= 1'b0;
            r_cap_zero <= 1'b0;
            r_cap_slot <= 4'd0;
            r_window   <= {SIZE_9{1'b0}};
        end else begin
            r_re_p     <= (w_state_nxt == S_READ) && !w_pad_nxt;
            if (w_state_nxt == S_READ) begin
                r_addr <= w_addr_nxt;
            end
            r_valid    <= (w_state_nxt == S_OUT);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_cap_vld  <= (r_state == S_READ);
            r_cap_zero <= !r_re_p;
            r_cap_slot <= r_k;
            for (int s = 0; s < 9; s++) begin
                if (r_cap_vld && (r_cap_slot == 4'(s))) begin
                    r_window[s*SIZE_1 +: SIZE_1] <= r_cap_zero ? {SIZE_1{1'b0}} : qp;
                end
            end
        end
    end

    assign re_p          = r_re_p;
    assign read_addressp = r_addr;
    assign window        = r_window;
    assign window_valid  = r_valid;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_cnn_window_reader.sv
// Self-checking bench for cnn_window_reader (picture_size 4) with a registered pixel memory,
// a window/address scoreboard built from the neighbourhood rules, and directed plus random scans.
module tb_cnn_window_reader;

    localparam int P  = 4;
    localparam int S1 = 11;
    localparam int S9 = 99;
    localparam int AW = 13;
`ifdef CNN_WIN_PAD_EN
    localparam int OFF    = 1;
    localparam int NR     = P;
    localparam int NW_LIT = 16;
`else
    localparam int OFF    = 0;
    localparam int NR     = P - 2;
    localparam int NW_LIT = 4;
`endif
    localparam int NW = NR * NR;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic                 re_p;
    logic [AW-1:0]        read_addressp;
    logic signed [S1-1:0] qp;
    logic signed [S9-1:0] window;
    logic                 window_valid;
    logic                 window_ready;
    logic                 busy;
    logic                 done;

    cnn_window_reader #(
        .picture_size(P), .SIZE_1(S1), .SIZE_9(S9), .SIZE_address_pix(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .re_p(re_p), .read_addressp(read_addressp), .qp(qp),
        .window(window), .window_valid(window_valid), .window_ready(window_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel memory with registered read; junk on qp when not reading.
    logic signed [S1-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (re_p) qp <= mem[read_addressp];
        else      qp <= S1'($urandom);
    end

    logic [S9-1:0] exp_win[$];
    logic [S9-1:0] acc_win[$];
    int            exp_addr[$];
    logic [S9-1:0] model_first, model_last;
    int n_tests = 0, n_fail = 0, n_acc = 0, n_done = 0;
    bit mon_en = 1'b0;

    task automatic check_w(input string name, input logic [S9-1:0] act, input logic [S9-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [S9-1:0] pack9(input int s0, s1, s2, s3, s4, s5, s6, s7, s8);
        logic [S9-1:0] w;
        int v [9];
        v = '{s0, s1, s2, s3, s4, s5, s6, s7, s8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*S1 +: S1] = S1'(v[k]);
        return w;
    endfunction

    // Reference: every window centre in row-major order, taps via plain coordinate arithmetic.
    task automatic build_expected(input logic [AW-1:0] base);
        exp_win.delete();
        exp_addr.delete();
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NR; c++) begin
                logic [S9-1:0] w;
                w = '0;
                for (int k = 0; k < 9; k++) begin
                    int rr, cc, a;
                    logic [AW-1:0] at;
                    rr = r + k / 3 - OFF;
                    cc = c + k % 3 - OFF;
                    a  = int'(base) + rr * P + cc;
                    at = AW'(a);
                    if (rr >= 0 && rr < P && cc >= 0 && cc < P) begin
                        w[k*S1 +: S1] = mem[at];
                        exp_addr.push_back(int'(at));
                    end
                end
                exp_win.push_back(w);
            end
        end
        model_first = exp_win[0];
        model_last  = exp_win[NW-1];
    endtask

    // Compare process: read addresses, presented windows and done, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (re_p) begin
                if (exp_addr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_read: addr %0d, no read expected", read_addressp);
                end else begin
                    check_i("read_addr", int'(read_addressp), exp_addr.pop_front());
                end
            end
            if (window_valid) begin
                check_i("re_p_while_valid", int'(re_p), 0);
                if (exp_win.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_window: got %h, no window expected", window);
                end else begin
                    check_w("window", window, exp_win[0]);
                    if (window_ready) begin
                        void'(exp_win.pop_front());
                        acc_win.push_back(window);
                        n_acc++;
                    end
                end
            end
            if (done) begin
                n_done++;
                check_i("busy_at_done", int'(busy), 0);
                check_i("windows_left_at_done", exp_win.size(), 0);
                check_i("reads_left_at_done", exp_addr.size(), 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall at window 1; 3: stray starts while busy.
    task automatic run_scan(input logic [AW-1:0] base, input int mode,
                            output int first_v, output int done_at, output int bp);
        int n;
        acc_win.delete();
        n_acc = 0; n_done = 0;
        build_expected(base);
        start = 1'b1; base_addr = base;
        cyc();
        start = 1'b0;
        n = 0; first_v = -1; done_at = -1; bp = 0;
        while (done_at < 0 && n < 3000) begin
            case (mode)
                1: window_ready = 1'($urandom);
                2: begin
                    if (window_valid && n_acc == 1 && bp < 5) begin
                        window_ready = 1'b0; bp++;
                    end else begin
                        window_ready = 1'b1;
                    end
                end
                3: begin
                    window_ready = 1'b1;
                    start     = (n == 3 || n == 25 || n == 38);
                    base_addr = AW'(100);
                end
                default: window_ready = 1'b1;
            endcase
            cyc();
            n++;
            if (first_v < 0 && window_valid) first_v = n;
            if (done) done_at = n;
        end
        start = 1'b0;
        window_ready = 1'b0;
        if (done_at < 0) begin
            n_tests++; n_fail++;
            $display("FAIL scan_timeout: no done within %0d cycles", n);
        end
        cyc();
        check_i("window_count", n_acc, NW_LIT);
        check_i("done_pulses", n_done, 1);
    endtask

    initial begin
        int fv, da, bp;
        for (int a = 0; a < (1 << AW); a++) mem[a] = S1'(a);
        rst = 1'b1; start = 1'b0; base_addr = '0; window_ready = 1'b0;
        repeat (3) cyc();
        check_i("rst_re_p", int'(re_p), 0);
        check_i("rst_addr", int'(read_addressp), 0);
        check_w("rst_window", window, '0);
        check_i("rst_valid", int'(window_valid), 0);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_done", int'(done), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Ready pulsed in IDLE is ignored.
        window_ready = 1'b1;
        repeat (4) cyc();
        check_i("idle_ready_busy", int'(busy), 0);
        check_i("idle_ready_valid", int'(window_valid), 0);
        window_ready = 1'b0;

        // Basic scan from base 0.
        run_scan(AW'(0), 0, fv, da, bp);
        check_i("first_valid_latency", fv, 10);
        check_i("done_latency", da, NW_LIT * 11);
`ifdef CNN_WIN_PAD_EN
        check_w("model_win0", model_first, pack9(0, 0, 0, 0, 0, 1, 0, 4, 5));
        check_w("model_win15", model_last, pack9(10, 11, 0, 14, 15, 0, 0, 0, 0));
        check_w("dut_win0", acc_win[0], pack9(0, 0, 0, 0, 0, 1, 0, 4, 5));
        check_w("dut_win15", acc_win[NW_LIT-1], pack9(10, 11, 0, 14, 15, 0, 0, 0, 0));
`else
        check_w("model_win0", model_first, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check_w("model_win3", model_last, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        check_w("dut_win0", acc_win[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check_w("dut_win3", acc_win[NW_LIT-1], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
`endif

        // Base offset.
        run_scan(AW'(16), 0, fv, da, bp);
`ifdef CNN_WIN_PAD_EN
        check_w("base16_win0", acc_win[0], pack9(0, 0, 0, 0, 16, 17, 0, 20, 21));
`else
        check_w("base16_win0", acc_win[0], pack9(16, 17, 18, 20, 21, 22, 24, 25, 26));
`endif

        // Backpressure on window 1.
        run_scan(AW'(0), 2, fv, da, bp);
        check_i("stall_cycles", bp, 5);
        check_i("stall_done_latency", da, NW_LIT * 11 + 5);

        // Reset during READ tap 4.
        build_expected(AW'(0));
        start = 1'b1; base_addr = '0;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        check_i("busy_before_reset", int'(busy), 1);
        check_i("re_p_tap4", int'(re_p), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        cyc();
        check_i("midrst_re_p", int'(re_p), 0);
        check_i("midrst_addr", int'(read_addressp), 0);
        check_w("midrst_window", window, '0);
        check_i("midrst_valid", int'(window_valid), 0);
        check_i("midrst_busy", int'(busy), 0);
        check_i("midrst_done", int'(done), 0);
        rst = 1'b0;
        exp_win.delete();
        exp_addr.delete();
        mon_en = 1'b1;
        repeat (2) cyc();
        check_i("post_rst_valid", int'(window_valid), 0);
        run_scan(AW'(0), 0, fv, da, bp);
        check_w("post_rst_win0", acc_win[0], model_first);
`ifndef CNN_WIN_PAD_EN
        check_w("post_rst_win0_lit", acc_win[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
`endif

        // Stray starts while busy.
        run_scan(AW'(0), 3, fv, da, bp);
        check_i("stray_start_done_latency", da, NW_LIT * 11);

        // Random memory, random bases (one near the top to wrap), random ready.
        for (int a = 0; a < (1 << AW); a++) mem[a] = S1'($urandom);
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] b;
            b = (t == 0) ? AW'(8190) : AW'($urandom);
            run_scan(b, (t == 1) ? 0 : 1, fv, da, bp);
            check_i("rand_first_valid", fv, 10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
